dac_stream_ctrl: RTL and testbench

Sample-rate scheduler and anti-pop controller placed in front of the sigma-delta DAC. It buffers incoming audio samples in a small FIFO and releases one sample per sample tick. A gain-ramp FSM fades the output to and from midscale, so enable and disable never produce a step at the DAC input. One instance drives each DAC channel.

---
 rtl/dac_stream_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dac_stream_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: per-channel sample scheduler and anti-pop gain ramp in
// front of the sigma-delta DAC. Samples queue in a small FIFO, one leaves per
// sample tick, and a gain FSM fades the output to and from midscale.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | output parked at midscale, FIFO held empty, writes dropped
// ST_RAMP_UP   | gain rising one step per tick toward unity
// ST_RUN       | unity gain, samples pass through unchanged
// ST_RAMP_DOWN | gain falling one step per tick toward zero
module dac_stream_ctrl #(
  parameter int MSBI       = 7,
  parameter int DIV        = 64,
  parameter int DEPTH_LOG2 = 2,
  parameter int GBITS      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic [MSBI:0]         S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic [MSBI:0]         DAC_DATA,
  output logic                  TICK,
  output logic                  UNDERRUN,
  output logic [DEPTH_LOG2:0]   LEVEL
);

  localparam int W   = MSBI + 1;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = MSBI + GBITS + 3;

  localparam logic [W-1:0]          MID_W     = W'(1 << MSBI);
  localparam logic signed [MSBI+1:0] MID_D    = (MSBI+2)'(1 << MSBI);
  localparam logic [DEPTH_LOG2:0]   DEPTH_L   = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [GBITS:0]        GAIN_UNITY = (GBITS+1)'(1 << GBITS);
  localparam logic [GBITS:0]        GAIN_ONE  = (GBITS+1)'(1);
  localparam logic [CW-1:0]         DIV_LAST  = CW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t state, next_state;
  logic [GBITS:0] gain, next_gain;
  logic           flush;

  logic [CW-1:0]          div_cnt;
  logic                   tick;
  logic [W-1:0]           mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]    level;
  logic [W-1:0]           held_smp;
  logic                   underrun_q;
  logic [W-1:0]           dac_q;
  logic                   active, s_ready_int, push, pop;

  logic signed [MSBI+1:0] d;
  logic signed [PW-1:0]   p;
  logic signed [PW-1:0]   p_sh;
  logic [W-1:0]           dac_next;
  logic                   unused_sign_bits;

  assign tick        = (div_cnt == DIV_LAST);
  assign active      = (state != ST_IDLE);
  assign s_ready_int = active ? (level < DEPTH_L) : 1'b1;
  assign push        = S_VALID & s_ready_int & active;
  assign pop         = tick & active & (level != '0);

  // Scaled output: signed offset from midscale times gain, floor-shifted back.
  // The shifted product always fits the DAC word, so only its low bits matter.
  always_comb begin
    d        = $signed({1'b0, held_smp}) - MID_D;
    p        = $signed({{(GBITS+1){d[MSBI+1]}}, d}) * $signed({{(MSBI+2){1'b0}}, gain});
    p_sh     = p >>> GBITS;
    dac_next = p_sh[W-1:0] + MID_W;
  end

  assign unused_sign_bits = ^p_sh[PW-1:W];

  // Gain ramp next-state; a reversal that lands on zero or unity goes straight
  // to IDLE or RUN so the gain never steps outside 0..unity.
  always_comb begin
    next_state = state;
    next_gain  = gain;
    flush      = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (ENABLE) begin
            next_gain  = GAIN_ONE;
            next_state = ST_RAMP_UP;
          end else begin
            next_gain  = '0;
          end
        end
        ST_RAMP_UP: begin
          if (!ENABLE) begin
            next_gain = gain - 1'b1;
            if (next_gain == '0) begin
              next_state = ST_IDLE;
              flush      = 1'b1;
            end else begin
              next_state = ST_RAMP_DOWN;
            end
          end else begin
            next_gain = gain + 1'b1;
            if (next_gain == GAIN_UNITY) next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          next_gain = GAIN_UNITY;
          if (!ENABLE) begin
            next_gain  = GAIN_UNITY - 1'b1;
            next_state = ST_RAMP_DOWN;
          end
        end
        ST_RAMP_DOWN: begin
          if (ENABLE) begin
            next_gain  = gain + 1'b1;
            next_state = (next_gain == GAIN_UNITY) ? ST_RUN : ST_RAMP_UP;
          end else begin
            next_gain = gain - 1'b1;
            if (next_gain == '0) begin
              next_state = ST_IDLE;
              flush      = 1'b1;
            end
          end
        end
        default: begin
          next_state = ST_IDLE;
          next_gain  = '0;
        end
      endcase
    end
  end

  // FSM state and gain register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      gain  <= '0;
    end else begin
      state <= next_state;
      gain  <= next_gain;
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= S_DATA;
  end

  // Divider, FIFO pointers, held sample, underrun strobe and DAC register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      div_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      held_smp   <= MID_W;
      underrun_q <= 1'b0;
      dac_q      <= MID_W;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      underrun_q <= tick & active & (level == '0);
      dac_q      <= dac_next;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        held_smp <= MID_W;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          held_smp <= mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  assign S_READY  = s_ready_int;
  assign DAC_DATA = dac_q;
  assign TICK     = tick;
  assign UNDERRUN = underrun_q;
  assign LEVEL    = level;

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Randomized bench for dac_stream_ctrl against a queue-based reference model.
module tb_dac_stream_ctrl;

  localparam int MSBI       = 7;
  localparam int DIV        = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int GBITS      = 4;
  localparam int MID        = 1 << MSBI;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int UNITY      = 1 << GBITS;

  localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

  logic                 CLK = 1'b0;
  logic                 RESET_N;
  logic                 ENABLE;
  logic [MSBI:0]        S_DATA;
  logic                 S_VALID;
  logic                 S_READY;
  logic [MSBI:0]        DAC_DATA;
  logic                 TICK;
  logic                 UNDERRUN;
  logic [DEPTH_LOG2:0]  LEVEL;

  dac_stream_ctrl #(
    .MSBI(MSBI), .DIV(DIV), .DEPTH_LOG2(DEPTH_LOG2), .GBITS(GBITS)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .DAC_DATA(DAC_DATA), .TICK(TICK), .UNDERRUN(UNDERRUN), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  int  m_cnt, m_gain, m_held, m_dac, m_mode;
  bit  m_und;
  int  q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_gain = 0;
    m_held = MID;
    m_dac  = MID;
    m_mode = M_IDLE;
    m_und  = 1'b0;
    q.delete();
  endtask

  // One clock edge of the reference behaviour, using the inputs driven this cycle.
  task automatic model_step();
    bit tick, ready, push, do_flush;
    int pval;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    tick     = (m_cnt == DIV - 1);
    ready    = (m_mode == M_IDLE) || (q.size() < DEPTH);
    push     = S_VALID && ready && (m_mode != M_IDLE);
    do_flush = 1'b0;

    pval  = (m_held - MID) * m_gain;
    m_dac = MID + (pval >>> GBITS);

    m_und = 1'b0;
    if (tick && m_mode != M_IDLE) begin
      if (q.size() > 0) m_held = q.pop_front();
      else m_und = 1'b1;
    end
    if (push) q.push_back(int'(S_DATA));

    if (tick) begin
      case (m_mode)
        M_IDLE: begin
          if (ENABLE) begin m_gain = 1; m_mode = M_UP; end
          else m_gain = 0;
        end
        M_UP: begin
          if (!ENABLE) begin
            m_gain--;
            if (m_gain == 0) do_flush = 1'b1; else m_mode = M_DOWN;
          end else begin
            m_gain++;
            if (m_gain == UNITY) m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (!ENABLE) begin m_gain = UNITY - 1; m_mode = M_DOWN; end
        end
        default: begin
          if (ENABLE) begin
            m_gain++;
            m_mode = (m_gain == UNITY) ? M_RUN : M_UP;
          end else begin
            m_gain--;
            if (m_gain == 0) do_flush = 1'b1;
          end
        end
      endcase
    end
    if (do_flush) begin
      m_mode = M_IDLE;
      q.delete();
      m_held = MID;
    end
    m_cnt = (m_cnt + 1) % DIV;
  endtask

  // phase table: enable mode (0 off, 1 on, 2 random toggle, 3 slow square),
  // valid percentage, data mode (0 FF, 1 00, 2 random, 3 extremes), reset injection
  int ph_en   [8] = '{1, 1, 0, 1, 2, 1, 2, 3};
  int ph_vpct [8] = '{100, 0, 50, 100, 30, 10, 60, 70};
  int ph_data [8] = '{0, 2, 2, 1, 2, 3, 3, 2};
  int ph_rst  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int extremes[5] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h81};

  initial begin
    int period;
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    S_VALID = 1'b0;
    S_DATA  = '0;
    model_reset();
    repeat (2) begin
      @(posedge CLK);
      model_step();
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    period  = 45;

    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < 400; c++) begin
        if (c != 0 || ph != 0) @(negedge CLK);
        cyc++;
        check_val("DAC_DATA", 32'(DAC_DATA), m_dac);
        check_val("TICK",     32'(TICK),     (m_cnt == DIV - 1) ? 1 : 0);
        check_val("S_READY",  32'(S_READY),  (m_mode == M_IDLE || q.size() < DEPTH) ? 1 : 0);
        check_val("LEVEL",    32'(LEVEL),    q.size());
        check_val("UNDERRUN", 32'(UNDERRUN), m_und ? 1 : 0);

        case (ph_en[ph])
          0: ENABLE = 1'b0;
          1: ENABLE = 1'b1;
          2: if ($urandom_range(0, 39) == 0) ENABLE = ~ENABLE;
          default: begin
            if (c % period == 0) begin
              ENABLE = ~ENABLE;
              period = 20 + int'($urandom_range(0, 60));
            end
          end
        endcase
        S_VALID = ($urandom_range(0, 99) < ph_vpct[ph]);
        case (ph_data[ph])
          0: S_DATA = 8'hFF;
          1: S_DATA = 8'h00;
          2: S_DATA = 8'($urandom);
          default: S_DATA = 8'(extremes[$urandom_range(0, 4)]);
        endcase
        RESET_N = (ph_rst[ph] != 0 && $urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;

        @(posedge CLK);
        model_step();
      end
    end

    @(negedge CLK);
    cyc++;
    check_val("DAC_DATA_end", 32'(DAC_DATA), m_dac);
    check_val("LEVEL_end",    32'(LEVEL),    q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
